// File: rtl/mold_gap_rerequest_pkg.sv
// mold_pkg: shared types and constants for the MoldUDP64 receive-side gap tracker.
//   SEQ_W / CNT_W : sequence number and message count widths
//   EOS_CNT       : message count value that marks end-of-session
//   SEQ_INIT      : first sequence number of a session
//   gap_state_e   : gap tracker FSM states
//   sat_cnt()     : clamp a 64-bit missing-message span to a request count
package mold_pkg;

  localparam int              SEQ_W    = 64;
  localparam int              CNT_W    = 16;
  localparam logic [CNT_W-1:0] EOS_CNT  = 16'hFFFF;
  localparam logic [SEQ_W-1:0] SEQ_INIT = 64'd1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    FAIL,
    EOS
  } gap_state_e;

  // 0xFFFF is never produced: it would read as end-of-session downstream.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [SEQ_W-1:0] span,
                                               input logic [CNT_W-1:0] max_cnt);
    logic [SEQ_W-1:0] max_wide;
    max_wide = {{(SEQ_W-CNT_W){1'b0}}, max_cnt};
    return (span > max_wide) ? max_cnt : span[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/mold_gap_rerequest_countdown.sv
// countdown: one-shot timer.
//   clk, nreset : clock, asynchronous active-low reset
//   start_v_i   : (re)load the counter with CNT_B and start counting
//   finished_o  : one-cycle pulse, CNT_B+1 cycles after the start_v_i cycle
module countdown #(
  parameter int              CNT_W = 14,
  parameter logic [CNT_W-1:0] CNT_B = 14'd10000
) (
  input  logic clk,
  input  logic nreset,
  input  logic start_v_i,
  output logic finished_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      finished_o <= 1'b0;
    end else if (start_v_i) begin
      cnt_q      <= CNT_B;
      busy_q     <= 1'b1;
      finished_o <= 1'b0;
    end else if (busy_q) begin
      if (cnt_q <= CNT_W'(1)) begin
        cnt_q      <= '0;
        busy_q     <= 1'b0;
        finished_o <= 1'b1;
      end else begin
        cnt_q      <= cnt_q - 1'b1;
        finished_o <= 1'b0;
      end
    end else begin
      finished_o <= 1'b0;
    end
  end

endmodule

// File: rtl/mold_gap_rerequest.sv
// mold_gap_rerequest: MoldUDP64 receive-side gap tracker and retransmission
// requester.
//   clk, nreset         : clock, asynchronous active-low reset
//   pkt_v_i/seq_i/cnt_i : decoded packet header (one-cycle pulse per packet)
//   req_v_o/req_ready_i : retransmission request handshake
//   req_seq_o/req_cnt_o : first missing sequence number, missing count (saturated)
//   expected_seq_o      : next in-order sequence number
//   gap_o               : a gap is outstanding
//   retry_fail_o        : sticky, retry budget exhausted
//   eos_o               : sticky, end-of-session reached
//
// Request handshake: req_v_o is held high with req_seq_o/req_cnt_o stable
// until the cycle req_ready_i is also high; that cycle is the transfer, and
// req_v_o drops on the next cycle.
module mold_gap_rerequest
  import mold_pkg::*;
#(
  parameter int                  TIMEOUT_W   = 14,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT     = 14'd10000,
  parameter int                  MAX_RETRY   = 3,
  parameter logic [CNT_W-1:0]    MAX_REQ_CNT = 16'hFFFE
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             pkt_v_i,
  input  logic [SEQ_W-1:0] pkt_seq_i,
  input  logic [CNT_W-1:0] pkt_cnt_i,
  output logic             req_v_o,
  input  logic             req_ready_i,
  output logic [SEQ_W-1:0] req_seq_o,
  output logic [CNT_W-1:0] req_cnt_o,
  output logic [SEQ_W-1:0] expected_seq_o,
  output logic             gap_o,
  output logic             retry_fail_o,
  output logic             eos_o
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  gap_state_e         state_q;
  logic [SEQ_W-1:0]   expected_seq_q;
  logic [SEQ_W-1:0]   gap_end_q;
  logic [RETRY_W-1:0] retry_q;
  logic               gap_q;
  logic               cd_finished;

  logic [SEQ_W-1:0] n_eff;
  logic [SEQ_W-1:0] pkt_end;
  logic             pkt_live;
  logic             is_eos;
  logic             is_adv;
  logic             is_gap;
  logic [SEQ_W-1:0] e_next;
  logic [SEQ_W-1:0] gap_end_next;
  logic             gap_pend;
  logic             gap_closed;
  logic             handshake;

  always_comb begin
    n_eff    = (pkt_cnt_i == EOS_CNT) ? '0 : {{(SEQ_W-CNT_W){1'b0}}, pkt_cnt_i};
    pkt_end  = pkt_seq_i + n_eff;
    pkt_live = pkt_v_i && (state_q != FAIL) && (state_q != EOS);
    is_eos   = pkt_live && (pkt_cnt_i == EOS_CNT) && (pkt_seq_i <= expected_seq_q);
    is_adv   = pkt_live && (pkt_seq_i <= expected_seq_q) && (expected_seq_q < pkt_end);
    is_gap   = pkt_live && (pkt_seq_i > expected_seq_q);
    e_next   = is_adv ? pkt_end : expected_seq_q;
    // The missing range is [E, S): the out-of-order packet's own messages are
    // not buffered, so the gap is closed once E reaches that packet's start.
    gap_end_next = (is_gap && (pkt_seq_i > gap_end_q)) ? pkt_seq_i : gap_end_q;
    gap_pend     = gap_q || is_gap;
    gap_closed   = gap_pend && (e_next >= gap_end_next);
    handshake    = (state_q == REQ) && req_ready_i;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q        <= IDLE;
      expected_seq_q <= SEQ_INIT;
      gap_end_q      <= '0;
      retry_q        <= '0;
      gap_q          <= 1'b0;
      req_seq_o      <= '0;
      req_cnt_o      <= '0;
    end else begin
      expected_seq_q <= e_next;
      gap_end_q      <= gap_end_next;
      gap_q          <= gap_pend && !gap_closed;
      // Closure wins over a same-cycle handshake: the budget restarts per gap.
      if (gap_closed) retry_q <= '0;
      else if (handshake) retry_q <= retry_q + 1'b1;

      if (is_eos) begin
        state_q <= EOS;
      end else begin
        case (state_q)
          IDLE: begin
            if (is_gap) begin
              state_q   <= REQ;
              req_seq_o <= expected_seq_q;
              req_cnt_o <= sat_cnt(gap_end_next - expected_seq_q, MAX_REQ_CNT);
            end
          end
          REQ: begin
            if (handshake) state_q <= gap_closed ? IDLE : WAIT;
          end
          WAIT: begin
            if (gap_closed) begin
              state_q <= IDLE;
            end else if (cd_finished) begin
              if (retry_q == RETRY_W'(MAX_RETRY)) begin
                state_q <= FAIL;
              end else begin
                state_q   <= REQ;
                req_seq_o <= e_next;
                req_cnt_o <= sat_cnt(gap_end_next - e_next, MAX_REQ_CNT);
              end
            end
          end
          default: state_q <= state_q;  // FAIL and EOS hold until reset
        endcase
      end
    end
  end

  countdown #(
    .CNT_W(TIMEOUT_W),
    .CNT_B(TIMEOUT)
  ) u_countdown (
    .clk       (clk),
    .nreset    (nreset),
    .start_v_i (handshake),
    .finished_o(cd_finished)
  );

  assign req_v_o        = (state_q == REQ);
  assign expected_seq_o = expected_seq_q;
  assign gap_o          = gap_q;
  assign retry_fail_o   = (state_q == FAIL);
  assign eos_o          = (state_q == EOS);

endmodule

// File: tb/tb_mold_gap_rerequest.sv
// tb_mold_gap_rerequest: directed bench for mold_gap_rerequest with a
// request scoreboard (expected {seq,cnt} queue popped on each handshake).
module tb_mold_gap_rerequest;

  localparam int T  = 8;
  localparam int MR = 2;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        pkt_v_i = 1'b0;
  logic [63:0] pkt_seq_i = '0;
  logic [15:0] pkt_cnt_i = '0;
  logic        req_v_o;
  logic        req_ready_i = 1'b0;
  logic [63:0] req_seq_o;
  logic [15:0] req_cnt_o;
  logic [63:0] expected_seq_o;
  logic        gap_o;
  logic        retry_fail_o;
  logic        eos_o;

  mold_gap_rerequest #(
    .TIMEOUT_W  (14),
    .TIMEOUT    (14'(T)),
    .MAX_RETRY  (MR),
    .MAX_REQ_CNT(16'hFFFE)
  ) dut (
    .clk           (clk),
    .nreset        (nreset),
    .pkt_v_i       (pkt_v_i),
    .pkt_seq_i     (pkt_seq_i),
    .pkt_cnt_i     (pkt_cnt_i),
    .req_v_o       (req_v_o),
    .req_ready_i   (req_ready_i),
    .req_seq_o     (req_seq_o),
    .req_cnt_o     (req_cnt_o),
    .expected_seq_o(expected_seq_o),
    .gap_o         (gap_o),
    .retry_fail_o  (retry_fail_o),
    .eos_o         (eos_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  logic [79:0] exp_q[$];
  int          hs_q[$];
  int          rise_q[$];
  logic        prev_req_v = 1'b0;
  logic [79:0] exp_item;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: a request transfers on every cycle with req_v_o && req_ready_i.
  always @(negedge clk) begin
    if (nreset && req_v_o && !prev_req_v) rise_q.push_back(cyc);
    prev_req_v = req_v_o;
    if (nreset && req_v_o && req_ready_i) begin
      hs_q.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL req_unexpected: got seq=%0h cnt=%0h want no request", req_seq_o, req_cnt_o);
      end else begin
        exp_item = exp_q.pop_front();
        if ({req_seq_o, req_cnt_o} !== exp_item) begin
          bad++;
          $display("FAIL req_payload: got seq=%0h cnt=%0h want seq=%0h cnt=%0h",
                   req_seq_o, req_cnt_o, exp_item[79:16], exp_item[15:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [63:0] seq, input logic [15:0] cnt);
    pkt_v_i   = 1'b1;
    pkt_seq_i = seq;
    pkt_cnt_i = cnt;
    tick();
    pkt_v_i   = 1'b0;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    tick();
    tick();
    nreset = 1'b1;
    tick();
  endtask

  int fail_cyc;
  int d_req;
  int d_fail;

  // ---------------- stimulus ----------------
  initial begin
    // 1. reset values, then reset while a request is pending
    req_ready_i = 1'b0;
    do_reset();
    check("rst_expected_seq", expected_seq_o, 64'd1);
    check("rst_req_v", {63'b0, req_v_o}, 64'd0);
    check("rst_gap", {63'b0, gap_o}, 64'd0);
    check("rst_retry_fail", {63'b0, retry_fail_o}, 64'd0);
    check("rst_eos", {63'b0, eos_o}, 64'd0);
    send_pkt(64'd5, 16'd0);
    check("pre_rst_req_v", {63'b0, req_v_o}, 64'd1);
    #1 nreset = 1'b0;
    #1;
    check("mid_rst_req_v", {63'b0, req_v_o}, 64'd0);
    check("mid_rst_gap", {63'b0, gap_o}, 64'd0);
    tick();
    nreset = 1'b1;
    tick();

    // 2. in-order stream and duplicate
    send_pkt(64'd1, 16'd3);
    send_pkt(64'd4, 16'd2);
    check("inorder_expected", expected_seq_o, 64'd6);
    send_pkt(64'd2, 16'd2);
    check("dup_expected", expected_seq_o, 64'd6);
    check("inorder_req_v", {63'b0, req_v_o}, 64'd0);

    // 3. gap, stalled request, fill
    exp_q.push_back({64'd6, 16'd4});
    send_pkt(64'd10, 16'd1);
    check("gap_req_v", {63'b0, req_v_o}, 64'd1);
    check("gap_req_seq", req_seq_o, 64'd6);
    check("gap_req_cnt", {48'b0, req_cnt_o}, 64'd4);
    check("gap_gap", {63'b0, gap_o}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_req_v", {63'b0, req_v_o}, 64'd1);
      check("stall_req_seq", req_seq_o, 64'd6);
      check("stall_req_cnt", {48'b0, req_cnt_o}, 64'd4);
    end
    req_ready_i = 1'b1;
    tick();
    req_ready_i = 1'b0;
    check("after_hs_req_v", {63'b0, req_v_o}, 64'd0);
    send_pkt(64'd6, 16'd4);
    check("fill_expected", expected_seq_o, 64'd10);
    check("fill_gap", {63'b0, gap_o}, 64'd0);
    for (int i = 0; i < T + 4; i++) tick();
    check("fill_no_rereq", {63'b0, req_v_o}, 64'd0);

    // 4. timeout exhaustion with ready tied high
    do_reset();
    hs_q.delete();
    rise_q.delete();
    req_ready_i = 1'b1;
    exp_q.push_back({64'd1, 16'd2});
    exp_q.push_back({64'd1, 16'd2});
    send_pkt(64'd3, 16'd0);
    fail_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (retry_fail_o) begin
        fail_cyc = cyc;
        break;
      end
    end
    check("retry_fail_rise", {63'b0, retry_fail_o}, 64'd1);
    check("hs_count", 64'(hs_q.size()), 64'd2);
    check("rise_count", 64'(rise_q.size()), 64'd2);
    d_req  = (hs_q.size() >= 1 && rise_q.size() >= 2) ? rise_q[1] - hs_q[0] : -1;
    d_fail = (hs_q.size() >= 2 && fail_cyc >= 0) ? fail_cyc - hs_q[1] : -1;
    check("rereq_delay", 64'(d_req), 64'(T + 2));
    check("fail_delay", 64'(d_fail), 64'(T + 2));
    for (int i = 0; i < 5; i++) tick();
    check("fail_sticky", {63'b0, retry_fail_o}, 64'd1);
    send_pkt(64'd1, 16'd5);
    check("fail_ignores_pkt", expected_seq_o, 64'd1);
    check("fail_req_v", {63'b0, req_v_o}, 64'd0);
    req_ready_i = 1'b0;

    // 5. request count saturation
    do_reset();
    exp_q.push_back({64'd1, 16'hFFFE});
    send_pkt(64'h1_0000_0000, 16'd0);
    check("sat_req_v", {63'b0, req_v_o}, 64'd1);
    check("sat_req_seq", req_seq_o, 64'd1);
    check("sat_req_cnt", {48'b0, req_cnt_o}, 64'hFFFE);
    req_ready_i = 1'b1;
    tick();
    req_ready_i = 1'b0;
    check("sat_gap_held", {63'b0, gap_o}, 64'd1);

    // 6. end-of-session
    do_reset();
    send_pkt(64'd1, 16'd5);
    check("eos_pre_expected", expected_seq_o, 64'd6);
    send_pkt(64'd6, 16'hFFFF);
    check("eos_flag", {63'b0, eos_o}, 64'd1);
    check("eos_expected", expected_seq_o, 64'd6);
    send_pkt(64'd20, 16'd1);
    tick();
    check("eos_no_req", {63'b0, req_v_o}, 64'd0);
    check("eos_no_gap", {63'b0, gap_o}, 64'd0);
    check("eos_sticky", {63'b0, eos_o}, 64'd1);

    // final report
    tick();
    tick();
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
